weight_fetch_unit: RTL and testbench

//  Streams a contiguous run of 32-bit weight words out of the weight SRAM wrapper into the PE array.

---
 rtl/wfu_pkg.sv | 19 +
 rtl/weight_fetch_unit_fifo.sv | 47 ++++
 rtl/weight_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_weight_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfu_pkg.sv
// Shared types and default widths for the weight fetch unit.
// Provides WRITE_DIS (byte write enables all inactive) when the SoC has not already defined it.
`ifndef WRITE_DIS
`define WRITE_DIS 4'b1111
`endif

package wfu_pkg;

  localparam int WFU_ADDR_W = 17;
  localparam int WFU_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } wfu_state_t;

endpackage

// File: rtl/weight_fetch_unit_fifo.sv
// Prefetch FIFO for the weight fetch unit: entries hold {last, data}.
// Storage is not reset; only the pointers are.
module weight_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/weight_fetch_unit.sv
// Streams base..base+len-1 weight words from the SRAM wrapper into the PE array.
// Optional feature macro: WFU_REPEAT_EN adds rep_i and streams the run rep_i times.
module weight_fetch_unit
  import wfu_pkg::*;
#(
  parameter int ADDR_W     = WFU_ADDR_W,
  parameter int DATA_W     = WFU_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  len_i,
`ifdef WFU_REPEAT_EN
  input  logic [CNT_W-1:0]  rep_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  input  logic              mem_gnt_i,
  output logic              mem_cs_o,
  output logic              mem_oe_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_wreq_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [DATA_W-1:0] w_data_o,
  output logic              w_last_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] OCC_MAX = (CW+1)'(FIFO_DEPTH);

  wfu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] base_q, rd_addr_q, sv_addr_q;
  logic [CNT_W-1:0]  len_q, rem_q, pass_q, sv_rem_q, sv_pass_q, reps;
  logic              inflight_q, infl_last_q;
  logic              start_ok, issue, capture, discard, last_of_pass;
  logic              pop, pop_last;
  logic [DATA_W:0]   fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occ;

`ifdef WFU_REPEAT_EN
  assign reps = (rep_i == '0) ? CNT_W'(1) : rep_i;
`else
  assign reps = CNT_W'(1);
`endif

  assign start_ok     = (state_q == IDLE) && start_i;
  assign occ          = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue        = (state_q == FETCH) && mem_gnt_i && (pass_q != '0)
                        && !fifo_full && (occ < OCC_MAX);
  assign last_of_pass = (rem_q == CNT_W'(1));
  // A read returns one cycle later; it only lands if the bus is still ours.
  assign capture      = inflight_q && mem_gnt_i;
  assign discard      = inflight_q && !mem_gnt_i;
  assign pop          = w_valid_o && w_ready_i;
  assign pop_last     = pop && fifo_rdata[DATA_W];

  weight_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .wdata ({infl_last_q, mem_rdata_i}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i != '0) ? FETCH : DONE;
      FETCH:   if (pop_last) state_d = DONE;
               else if ((pass_q == '0) && !inflight_q) state_d = DRAIN;
      DRAIN:   if (pop_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      rem_q      <= '0;
      pass_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (start_ok) begin
        rem_q  <= len_i;
        pass_q <= (len_i == '0) ? '0 : reps;
      end else if (issue) begin
        if (last_of_pass) begin
          rem_q  <= len_q;
          pass_q <= pass_q - CNT_W'(1);
        end else begin
          rem_q  <= rem_q - CNT_W'(1);
        end
      end else if (discard) begin
        rem_q  <= sv_rem_q;
        pass_q <= sv_pass_q;
      end
    end
  end

  // Address path; sv_* snapshot the issue so a dropped grant can rewind exactly one word.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      base_q    <= base_i;
      len_q     <= len_i;
      rd_addr_q <= base_i;
    end else if (issue) begin
      sv_addr_q   <= rd_addr_q;
      sv_rem_q    <= rem_q;
      sv_pass_q   <= pass_q;
      infl_last_q <= last_of_pass && (pass_q == CNT_W'(1));
      rd_addr_q   <= last_of_pass ? base_q : rd_addr_q + ADDR_W'(1);
    end else if (discard) begin
      rd_addr_q <= sv_addr_q;
    end
  end

  assign busy_o      = (state_q == FETCH) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign mem_cs_o    = issue;
  assign mem_oe_o    = issue;
  assign mem_addr_o  = issue ? rd_addr_q : '0;
  assign mem_wreq_o  = `WRITE_DIS;
  assign mem_wdata_o = '0;
  assign w_valid_o   = !fifo_empty;
  assign w_data_o    = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
  assign w_last_o    = !fifo_empty && fifo_rdata[DATA_W];

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Self-checking bench for weight_fetch_unit: SRAM model, output monitor and word-list reference model.
`ifndef WRITE_DIS
`define WRITE_DIS 4'b1111
`endif

module tb_weight_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [16:0] base_i;
  logic [16:0] len_i;
`ifdef WFU_REPEAT_EN
  logic [16:0] rep_i;
`endif
  logic        busy_o, done_o;
  logic        mem_gnt_i, mem_cs_o, mem_oe_o;
  logic [16:0] mem_addr_o;
  logic [3:0]  mem_wreq_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic        w_valid_o, w_ready_i, w_last_o;
  logic [31:0] w_data_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc;

  logic [31:0] got_d[$];
  bit          got_l[$];
  logic [31:0] exp_d[$];
  logic [16:0] iss_a[$];
  int          iss_c[$];
  int          done_n, done_cyc, last_cyc, first_cs, first_val, stab_err;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  weight_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_i      (base_i),
    .len_i       (len_i),
`ifdef WFU_REPEAT_EN
    .rep_i       (rep_i),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_cs_o    (mem_cs_o),
    .mem_oe_o    (mem_oe_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wreq_o  (mem_wreq_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .w_valid_o   (w_valid_o),
    .w_ready_i   (w_ready_i),
    .w_data_o    (w_data_o),
    .w_last_o    (w_last_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(input logic [16:0] a);
    return {a[14:0] ^ 15'h2B3C, a};
  endfunction

  // SRAM: one-cycle read latency, garbage on cycles with no read
  always @(posedge clk) begin
    if (mem_cs_o && mem_oe_o) mem_rdata_i <= word_at(mem_addr_o);
    else                      mem_rdata_i <= 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (w_valid_o && w_ready_i) begin
      got_d.push_back(w_data_o);
      got_l.push_back(w_last_o);
      if (w_last_o) last_cyc = cyc;
    end
    if (w_valid_o && first_val < 0) first_val = cyc;
    if (mem_cs_o) begin
      iss_a.push_back(mem_addr_o);
      iss_c.push_back(cyc);
      if (first_cs < 0) first_cs = cyc;
    end
    if (done_o) begin
      done_n++;
      done_cyc = cyc;
    end
    if (!rst) prev_hold = 1'b0;
    else begin
      if (prev_hold && (w_valid_o !== 1'b1 || w_data_o !== prev_data || w_last_o !== prev_last))
        stab_err++;
      prev_hold = w_valid_o && !w_ready_i;
      prev_data = w_data_o;
      prev_last = w_last_o;
    end
  end

  // -1: exact match; -2: wrong word count; else first wrong index
  function automatic int word_check();
    if (got_d.size() != exp_d.size()) return -2;
    foreach (exp_d[i])
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1)) return i;
    return -1;
  endfunction

  task automatic run_xfer(input logic [16:0] base, input int len, input int rep,
                          input int gnt_pct, input int rdy_pct, input int rdy_hold,
                          input int drop_at, input int restart_at, output bit timed_out);
    int n;
    int rep_eff;
    bit dropped;
    got_d.delete(); got_l.delete(); iss_a.delete(); iss_c.delete(); exp_d.delete();
    done_n = 0; done_cyc = -1; last_cyc = -1; first_cs = -1; first_val = -1; stab_err = 0;
    rep_eff = (rep == 0) ? 1 : rep;
`ifndef WFU_REPEAT_EN
    rep_eff = 1;
`endif
    for (int p = 0; p < rep_eff; p++)
      for (int i = 0; i < len; i++) exp_d.push_back(word_at(17'(base + 17'(i))));
    base_i = base;
    len_i = 17'(len);
`ifdef WFU_REPEAT_EN
    rep_i = 17'(rep);
`endif
    start_i = 1'b1;
    mem_gnt_i = 1'b1;
    w_ready_i = (rdy_hold == 0);
    start_cyc = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0;
    dropped = 1'b0;
    while (done_n == 0 && n < 400) begin
      start_i = (n == restart_at);
      if (start_i) begin
        base_i = base ^ 17'h00155;
        len_i = 17'(len + 3);
      end
      mem_gnt_i = ($urandom_range(99) < gnt_pct);
      if (drop_at > 0 && !dropped && iss_a.size() == drop_at) begin
        mem_gnt_i = 1'b0;
        dropped = 1'b1;
      end
      w_ready_i = (n < rdy_hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      @(posedge clk); #1;
      n++;
    end
    start_i = 1'b0;
    mem_gnt_i = 1'b1;
    w_ready_i = 1'b1;
    timed_out = (done_n == 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start_i = 0; base_i = '0; len_i = '0; mem_gnt_i = 1; w_ready_i = 1;
`ifdef WFU_REPEAT_EN
    rep_i = '0;
`endif
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy_o, done_o, mem_cs_o, mem_oe_o, mem_addr_o, mem_wdata_o, w_valid_o, w_data_o, w_last_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b cs=%b oe=%b addr=%h wdata=%h valid=%b data=%h last=%b, all need 0",
               busy_o, done_o, mem_cs_o, mem_oe_o, mem_addr_o, mem_wdata_o, w_valid_o, w_data_o, w_last_o);
    end
    total++;
    if (mem_wreq_o !== `WRITE_DIS) begin
      bad++;
      $display("FAIL reset_wreq: got %b need %b", mem_wreq_o, `WRITE_DIS);
    end
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit to;
    bit addr_ok;
    int wc;
    run_xfer(17'h00010, 8, 1, 100, 100, 0, 0, -1, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout: no done_o"); end
    wc = word_check();
    total++; if (wc != -1) begin bad++; $display("FAIL basic_words: idx %0d got %0d words need %0d", wc, got_d.size(), exp_d.size()); end
    addr_ok = (iss_a.size() == 8);
    foreach (iss_a[i]) if (iss_a[i] !== 17'(17'h10 + 17'(i)) || iss_c[i] != start_cyc + 1 + i) addr_ok = 0;
    total++; if (!addr_ok) begin bad++; $display("FAIL basic_addrs: got %0d issues, first %h, need 0x10..0x17 back to back", iss_a.size(), iss_a.size() ? iss_a[0] : 17'h0); end
    total++; if (first_cs != start_cyc + 1) begin bad++; $display("FAIL basic_cs_latency: got %0d need %0d", first_cs - start_cyc, 1); end
    total++; if (first_val != start_cyc + 3) begin bad++; $display("FAIL basic_valid_latency: got %0d need %0d", first_val - start_cyc, 3); end
    total++; if (last_cyc != start_cyc + 10) begin bad++; $display("FAIL basic_throughput: last at +%0d need +10", last_cyc - start_cyc); end
    total++; if (done_n != 1 || done_cyc != last_cyc + 1) begin bad++; $display("FAIL basic_done: count %0d at +%0d need 1 at +%0d", done_n, done_cyc - start_cyc, last_cyc + 1 - start_cyc); end
  endtask

  task automatic test_backpressure();
    bit to;
    int wc;
    int early;
    run_xfer(17'h00040, 6, 1, 100, 100, 10, 0, -1, to);
    early = 0;
    foreach (iss_c[i]) if (iss_c[i] <= start_cyc + 10) early++;
    total++; if (early != 4) begin bad++; $display("FAIL bp_issue_limit: got %0d reads while stalled need 4", early); end
    wc = word_check();
    total++; if (to || wc != -1) begin bad++; $display("FAIL bp_words: timeout=%0d idx %0d got %0d need %0d", to, wc, got_d.size(), exp_d.size()); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles need 0", stab_err); end
  endtask

  task automatic test_gnt_drop();
    bit to;
    bit addr_ok;
    int wc;
    logic [16:0] exp_a[$];
    exp_a = '{17'h80, 17'h81, 17'h81, 17'h82, 17'h83, 17'h84};
    run_xfer(17'h00080, 5, 1, 100, 100, 0, 2, -1, to);
    wc = word_check();
    total++; if (to || wc != -1) begin bad++; $display("FAIL gnt_words: timeout=%0d idx %0d got %0d need %0d", to, wc, got_d.size(), exp_d.size()); end
    addr_ok = (iss_a.size() == exp_a.size());
    foreach (iss_a[i]) if (i >= exp_a.size() || iss_a[i] !== exp_a[i]) addr_ok = 0;
    total++; if (!addr_ok) begin bad++; $display("FAIL gnt_reissue: got %0d issues need 6 (0x81 twice)", iss_a.size()); end
    total++; if (done_n != 1) begin bad++; $display("FAIL gnt_done: got %0d need 1", done_n); end
  endtask

  task automatic test_wrap();
    bit to;
    bit addr_ok;
    int wc;
    logic [16:0] exp_a[$];
    exp_a = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    run_xfer(17'h1FFFE, 4, 1, 100, 100, 0, 0, -1, to);
    addr_ok = (iss_a.size() == 4);
    foreach (iss_a[i]) if (i >= 4 || iss_a[i] !== exp_a[i]) addr_ok = 0;
    total++; if (!addr_ok) begin bad++; $display("FAIL wrap_addrs: got %0d issues, third %h need 1FFFE,1FFFF,0,1", iss_a.size(), iss_a.size() > 2 ? iss_a[2] : 17'h0); end
    wc = word_check();
    total++; if (to || wc != -1) begin bad++; $display("FAIL wrap_words: timeout=%0d idx %0d", to, wc); end
  endtask

  task automatic test_zero_len();
    bit to;
    run_xfer(17'h00005, 0, 1, 100, 100, 0, 0, -1, to);
    total++; if (to || done_n != 1 || done_cyc != start_cyc + 1) begin bad++; $display("FAIL zero_done: count %0d at +%0d need 1 at +1", done_n, done_cyc - start_cyc); end
    total++; if (iss_a.size() != 0 || got_d.size() != 0) begin bad++; $display("FAIL zero_activity: got %0d reads %0d words need 0", iss_a.size(), got_d.size()); end
  endtask

  task automatic test_busy_start();
    bit to;
    bit addr_ok;
    int wc;
    run_xfer(17'h00180, 6, 1, 100, 100, 0, 0, 2, to);
    wc = word_check();
    total++; if (to || wc != -1) begin bad++; $display("FAIL busy_start_words: timeout=%0d idx %0d got %0d need %0d", to, wc, got_d.size(), exp_d.size()); end
    addr_ok = (iss_a.size() == 6);
    foreach (iss_a[i]) if (iss_a[i] !== 17'(17'h180 + 17'(i))) addr_ok = 0;
    total++; if (!addr_ok) begin bad++; $display("FAIL busy_start_addrs: got %0d issues need 6 from 0x180", iss_a.size()); end
    total++; if (done_n != 1) begin bad++; $display("FAIL busy_start_done: got %0d need 1", done_n); end
  endtask

  task automatic test_mid_reset();
    bit to;
    int wc;
    base_i = 17'h00300; len_i = 17'd8; start_i = 1; mem_gnt_i = 1; w_ready_i = 1;
    done_n = 0;
    @(posedge clk); #1;
    start_i = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy_o !== 1'b1 || mem_cs_o !== 1'b1) begin bad++; $display("FAIL midrst_pre: busy=%b cs=%b need 1 1", busy_o, mem_cs_o); end
    rst = 0;
    @(posedge clk); #1;
    total++; if ({mem_cs_o, w_valid_o, busy_o, done_o} !== 4'b0000) begin bad++; $display("FAIL midrst_abort: cs=%b valid=%b busy=%b done=%b need 0000", mem_cs_o, w_valid_o, busy_o, done_o); end
    rst = 1;
    repeat (6) @(posedge clk);
    #1;
    total++; if (done_n != 0) begin bad++; $display("FAIL midrst_no_done: got %0d done pulses need 0", done_n); end
    run_xfer(17'h00310, 3, 1, 100, 100, 0, 0, -1, to);
    wc = word_check();
    total++; if (to || wc != -1) begin bad++; $display("FAIL midrst_after: timeout=%0d idx %0d got %0d need %0d", to, wc, got_d.size(), exp_d.size()); end
  endtask

  task automatic test_random();
    bit to;
    int wc;
    int len;
    for (int k = 0; k < 8; k++) begin
      len = int'($urandom_range(12, 1));
      run_xfer(17'($urandom_range(17'h1FFFF)), len, int'($urandom_range(3)),
               int'($urandom_range(100, 50)), int'($urandom_range(100, 40)), 0, 0, -1, to);
      wc = word_check();
      total++; if (to || wc != -1) begin bad++; $display("FAIL rand%0d_words: timeout=%0d idx %0d got %0d need %0d", k, to, wc, got_d.size(), exp_d.size()); end
      total++; if (done_n != 1 || done_cyc != last_cyc + 1) begin bad++; $display("FAIL rand%0d_done: count %0d at %0d need 1 at %0d", k, done_n, done_cyc, last_cyc + 1); end
      total++; if (stab_err != 0) begin bad++; $display("FAIL rand%0d_stable: got %0d unstable cycles need 0", k, stab_err); end
    end
  endtask

`ifdef WFU_REPEAT_EN
  task automatic test_repeat();
    bit to;
    int wc;
    run_xfer(17'h00020, 3, 2, 100, 100, 0, 0, -1, to);
    wc = word_check();
    total++; if (to || wc != -1) begin bad++; $display("FAIL repeat_words: timeout=%0d idx %0d got %0d need %0d", to, wc, got_d.size(), exp_d.size()); end
    total++; if (last_cyc != start_cyc + 8) begin bad++; $display("FAIL repeat_no_bubble: last at +%0d need +8", last_cyc - start_cyc); end
    run_xfer(17'h00050, 2, 0, 100, 100, 0, 0, -1, to);
    wc = word_check();
    total++; if (to || wc != -1) begin bad++; $display("FAIL repeat_zero_rep: idx %0d got %0d need %0d", wc, got_d.size(), exp_d.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gnt_drop();
    test_wrap();
    test_zero_len();
    test_busy_start();
    test_mid_reset();
`ifdef WFU_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
